global_bram_arbiter: RTL and testbench

GLOBAL_BRAM_ARBITER -- requirements
Module: global_bram_arbiter

---
 rtl/global_bram_arbiter.sv | 153 +++++++++++++++
 tb/tb_global_bram_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_bram_arbiter.sv
// Global BRAM port arbiter: shares one BRAM port between the fused loader
// reads and a buffered stream of result writes to the OFM region.
module global_bram_arbiter #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int HI_WM      = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    output logic              rd_gnt,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              ofm_start,
    input  logic [31:0]       base_addr_OFM,
    output logic              bram_en,
    output logic              bram_we,
    output logic [31:0]       bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [3:0]        fifo_count,
    output logic [31:0]       ofm_wr_count,
    output logic              idle
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;
    logic [31:0]       ofm_ptr;
    logic              wr_gnt;
    logic              push;
    logic              pop;
    logic              nonempty;
    logic              hi;
    logic              starved;

    assign nonempty = (count != '0);
    assign hi       = (count >= CW'(HI_WM));
    assign starved  = nonempty & (starve_cnt == SW'(STARVE_MAX));
    assign wr_ready = (count < CW'(FIFO_DEPTH));
    assign push     = wr_valid & wr_ready;
    assign pop      = wr_gnt;

    // Strict-priority grant: watermark, starvation, read, then drain.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (reset_n) begin
            if (hi) begin
                wr_gnt = 1'b1;
            end else if (starved) begin
                wr_gnt = 1'b1;
            end else if (rd_req) begin
                rd_gnt = 1'b1;
            end else if (nonempty) begin
                wr_gnt = 1'b1;
            end
        end
    end

    // BRAM port mux: idle port drives zeros on address and data.
    always_comb begin
        bram_en    = rd_gnt | wr_gnt;
        bram_we    = wr_gnt;
        bram_addr  = '0;
        bram_wdata = '0;
        if (rd_gnt) begin
            bram_addr = rd_addr;
        end else if (wr_gnt) begin
            bram_addr  = ofm_ptr;
            bram_wdata = mem[rd_ptr];
        end
    end

    // Write buffer storage; contents need no reset, pointers gate use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Write buffer pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Count reads that overtake a waiting write; saturate at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (wr_gnt || !nonempty) begin
            starve_cnt <= '0;
        end else if (rd_gnt && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // OFM write pointer; a start pulse wins over the advance of a
    // coincident write, which itself still uses the old pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ofm_ptr      <= '0;
            ofm_wr_count <= '0;
        end else if (ofm_start) begin
            ofm_ptr      <= base_addr_OFM;
            ofm_wr_count <= '0;
        end else if (wr_gnt) begin
            ofm_ptr      <= ofm_ptr + 32'd4;
            ofm_wr_count <= ofm_wr_count + 32'd1;
        end
    end

    // Read data is valid one cycle after its grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_gnt;
        end
    end

    assign rd_data    = bram_rdata;
    assign fifo_count = 4'(count);
    assign idle       = ~nonempty & ~rd_data_valid;

endmodule

// File: tb/tb_global_bram_arbiter.sv
// Bench for global_bram_arbiter: scenario tasks plus a scoreboard that
// tracks expected read data and expected write data/addresses.
module tb_global_bram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_gnt;
    logic        rd_data_valid;
    logic [31:0] rd_data;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        ofm_start;
    logic [31:0] base_addr_OFM;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata = '0;
    logic [3:0]  fifo_count;
    logic [31:0] ofm_wr_count;
    logic        idle;

    logic        f_rd_req;
    logic        f_rd_gnt;
    logic        f_rd_data_valid;
    logic [31:0] f_rd_data;
    logic        f_wr_valid;
    logic [31:0] f_wr_data;
    logic        f_wr_ready;
    logic        f_bram_en;
    logic        f_bram_we;
    logic [31:0] f_bram_addr;
    logic [31:0] f_bram_wdata;
    logic [3:0]  f_fifo_count;
    logic [31:0] f_ofm_wr_count;
    logic        f_idle;

    int          pass_cnt = 0;
    int          total = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] f_got[$];
    logic [31:0] m_ptr = '0;

    always #5 clk = ~clk;

    global_bram_arbiter u_dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .ofm_start(ofm_start), .base_addr_OFM(base_addr_OFM),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .fifo_count(fifo_count), .ofm_wr_count(ofm_wr_count), .idle(idle)
    );

    // Instance whose watermark equals its depth so the buffer can fill.
    global_bram_arbiter #(.HI_WM(8), .STARVE_MAX(15)) u_full (
        .clk(clk), .reset_n(reset_n),
        .rd_req(f_rd_req), .rd_addr(32'h0), .rd_gnt(f_rd_gnt),
        .rd_data_valid(f_rd_data_valid), .rd_data(f_rd_data),
        .wr_valid(f_wr_valid), .wr_data(f_wr_data), .wr_ready(f_wr_ready),
        .ofm_start(1'b0), .base_addr_OFM(32'h0),
        .bram_en(f_bram_en), .bram_we(f_bram_we), .bram_addr(f_bram_addr),
        .bram_wdata(f_bram_wdata), .bram_rdata(32'h0),
        .fifo_count(f_fifo_count), .ofm_wr_count(f_ofm_wr_count),
        .idle(f_idle)
    );

    // BRAM model: 1-cycle read latency, data = ~address.
    always @(posedge clk) begin
        if (bram_en && !bram_we) bram_rdata <= ~bram_addr;
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_data_valid) begin
                total++;
                if (rd_q.size() == 0) begin
                    $display("FAIL rd_unexpected: rd_data=%h with no read pending", rd_data);
                end else begin
                    logic [31:0] e;
                    e = rd_q.pop_front();
                    if (rd_data !== e) $display("FAIL rd_data: got %h want %h", rd_data, e);
                    else pass_cnt++;
                end
            end
            if (rd_gnt) begin
                total++;
                if (!rd_req || bram_we !== 1'b0 || bram_en !== 1'b1 || bram_addr !== rd_addr)
                    $display("FAIL rd_grant: req=%b en=%b we=%b addr=%h want addr %h",
                             rd_req, bram_en, bram_we, bram_addr, rd_addr);
                else pass_cnt++;
                rd_q.push_back(~rd_addr);
            end
            if (bram_we) begin
                total++;
                if (wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected: addr=%h data=%h", bram_addr, bram_wdata);
                end else begin
                    logic [31:0] e;
                    e = wr_q.pop_front();
                    if (bram_wdata !== e || bram_addr !== m_ptr || bram_en !== 1'b1)
                        $display("FAIL wr_beat: got %h@%h want %h@%h",
                                 bram_wdata, bram_addr, e, m_ptr);
                    else pass_cnt++;
                end
                m_ptr = m_ptr + 32'd4;
            end
            if (wr_valid && wr_ready) wr_q.push_back(wr_data);
            if (ofm_start) m_ptr = base_addr_OFM;
        end
    end

    always @(negedge clk) begin
        if (reset_n && f_bram_we) f_got.push_back(f_bram_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rd_req = 1'b1; rd_addr = 32'h44;
        wr_valid = 1'b0; wr_data = '0; ofm_start = 1'b0; base_addr_OFM = '0;
        f_rd_req = 1'b0; f_wr_valid = 1'b0; f_wr_data = '0;
        #3;
        total++;
        if ({bram_en, bram_we, rd_gnt, rd_data_valid} !== 4'b0000)
            $display("FAIL reset_ctl: en/we/gnt/vld=%b%b%b%b want 0000",
                     bram_en, bram_we, rd_gnt, rd_data_valid);
        else pass_cnt++;
        total++;
        if ({wr_ready, idle} !== 2'b11 || fifo_count !== 4'd0)
            $display("FAIL reset_status: ready=%b idle=%b cnt=%0d want 1 1 0",
                     wr_ready, idle, fifo_count);
        else pass_cnt++;
        total++;
        if (bram_addr !== 32'h0 || bram_wdata !== 32'h0)
            $display("FAIL reset_bus: addr=%h wdata=%h want 0 0", bram_addr, bram_wdata);
        else pass_cnt++;
        step(); step();
        reset_n = 1'b1; rd_req = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (idle !== 1'b1 || bram_en !== 1'b0 || ofm_wr_count !== 32'h0)
            $display("FAIL after_reset: idle=%b en=%b wcnt=%0d want 1 0 0",
                     idle, bram_en, ofm_wr_count);
        else pass_cnt++;
    endtask

    task automatic test_read();
        step();
        rd_req = 1'b1; rd_addr = 32'h100;
        @(negedge clk);
        total++;
        if (rd_gnt !== 1'b1 || bram_addr !== 32'h100 || bram_we !== 1'b0)
            $display("FAIL read_grant: gnt=%b addr=%h we=%b want 1 100 0",
                     rd_gnt, bram_addr, bram_we);
        else pass_cnt++;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        total++;
        if (rd_data_valid !== 1'b1 || rd_data !== 32'hFFFF_FEFF || rd_gnt !== 1'b0)
            $display("FAIL read_data: vld=%b data=%h gnt=%b want 1 fffffeff 0",
                     rd_data_valid, rd_data, rd_gnt);
        else pass_cnt++;
        step();
        @(negedge clk);
        total++;
        if (rd_data_valid !== 1'b0)
            $display("FAIL read_pulse: vld=%b want 0", rd_data_valid);
        else pass_cnt++;
    endtask

    task automatic test_write_drain();
        logic [31:0] a[3];
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            ofm_start = (i == 0);
            base_addr_OFM = 32'h2000;
            wr_valid = (i >= 1 && i <= 3);
            wr_data = 32'hD000_0000 + i;
            @(negedge clk);
            if (bram_we) begin
                if (n < 3) a[n] = bram_addr;
                n++;
            end
        end
        wr_valid = 1'b0;
        total++;
        if (n != 3 || a[0] !== 32'h2000 || a[1] !== 32'h2004 || a[2] !== 32'h2008)
            $display("FAIL drain_addr: n=%0d addrs=%h %h %h want 3 2000 2004 2008",
                     n, a[0], a[1], a[2]);
        else pass_cnt++;
        total++;
        if (ofm_wr_count !== 32'd3 || idle !== 1'b1)
            $display("FAIL drain_end: wcnt=%0d idle=%b want 3 1", ofm_wr_count, idle);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic [6:0] rv;
        logic [6:0] wv;
        for (int i = 0; i < 7; i++) begin
            step();
            rd_req = 1'b1; rd_addr = 32'h40;
            wr_valid = (i == 0); wr_data = 32'h5A5A_0001;
            @(negedge clk);
            rv[i] = rd_gnt;
            wv[i] = bram_we;
        end
        step();
        rd_req = 1'b0;
        total++;
        if (rv !== 7'b1011111)
            $display("FAIL starve_reads: got %b want 1011111", rv);
        else pass_cnt++;
        total++;
        if (wv !== 7'b0100000)
            $display("FAIL starve_write: got %b want 0100000", wv);
        else pass_cnt++;
    endtask

    task automatic test_ofm_collision();
        step();
        wr_valid = 1'b1; wr_data = 32'hC011_0000;
        step();
        wr_valid = 1'b0; ofm_start = 1'b1; base_addr_OFM = 32'h3000;
        @(negedge clk);
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 32'h2010)
            $display("FAIL collide_old: we=%b addr=%h want 1 2010", bram_we, bram_addr);
        else pass_cnt++;
        step();
        ofm_start = 1'b0; wr_valid = 1'b1; wr_data = 32'hC011_0001;
        @(negedge clk);
        total++;
        if (ofm_wr_count !== 32'd0 || bram_we !== 1'b0)
            $display("FAIL collide_clr: wcnt=%0d we=%b want 0 0", ofm_wr_count, bram_we);
        else pass_cnt++;
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 32'h3000)
            $display("FAIL collide_new: we=%b addr=%h want 1 3000", bram_we, bram_addr);
        else pass_cnt++;
        step();
        @(negedge clk);
        total++;
        if (ofm_wr_count !== 32'd1)
            $display("FAIL collide_cnt: wcnt=%0d want 1", ofm_wr_count);
        else pass_cnt++;
    endtask

    task automatic test_watermark();
        int mx = 0;
        int viol = 0;
        int hic = 0;
        int k = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            rd_req = 1'b1; rd_addr = 32'h80;
            wr_valid = (i < 8); wr_data = 32'hAB00_0000 + i;
            @(negedge clk);
            if (int'(fifo_count) > mx) mx = int'(fifo_count);
            if (fifo_count >= 4'd6) begin
                hic++;
                if (!bram_we) viol++;
            end
        end
        step();
        rd_req = 1'b0; wr_valid = 1'b0;
        while (k < 20 && !(idle && fifo_count == 4'd0)) begin
            step();
            k++;
        end
        total++;
        if (mx != 6 || hic != 2 || viol != 0)
            $display("FAIL hi_wm: max=%0d hi_cycles=%0d viol=%0d want 6 2 0", mx, hic, viol);
        else pass_cnt++;
        total++;
        if (k >= 20)
            $display("FAIL hi_drain: fifo_count=%0d idle=%b after 20 cycles", fifo_count, idle);
        else pass_cnt++;
    endtask

    task automatic test_full();
        int bad = 0;
        int k = 0;
        int e = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            f_rd_req = 1'b1; f_wr_valid = 1'b1; f_wr_data = 32'hF000_0000 + i;
            @(negedge clk);
            if (i < 8 && (f_bram_we || !f_wr_ready || !f_rd_gnt)) bad++;
        end
        total++;
        if (bad != 0 || f_fifo_count !== 4'd8 || f_wr_ready !== 1'b0)
            $display("FAIL full_state: bad=%0d cnt=%0d ready=%b want 0 8 0",
                     bad, f_fifo_count, f_wr_ready);
        else pass_cnt++;
        total++;
        if (f_bram_we !== 1'b1 || f_bram_wdata !== 32'hF000_0000)
            $display("FAIL full_wr: we=%b data=%h want 1 f0000000", f_bram_we, f_bram_wdata);
        else pass_cnt++;
        step();
        f_wr_valid = 1'b0; f_rd_req = 1'b0;
        while (k < 20 && f_fifo_count != 4'd0) begin
            step();
            k++;
        end
        step();
        for (int i = 0; i < f_got.size(); i++)
            if (f_got[i] !== 32'hF000_0000 + i) e++;
        total++;
        if (f_got.size() != 8 || e != 0)
            $display("FAIL full_drop: writes=%0d order_err=%0d want 8 0", f_got.size(), e);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int w = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            rd_req = 1'b1; rd_addr = 32'hC0;
            wr_valid = 1'b1; wr_data = 32'hEE00_0000 + i;
        end
        step();
        wr_valid = 1'b0;
        total++;
        if (fifo_count !== 4'd5 || rd_data_valid !== 1'b1)
            $display("FAIL mid_pre: cnt=%0d vld=%b want 5 1", fifo_count, rd_data_valid);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        rd_q.delete();
        wr_q.delete();
        m_ptr = '0;
        total++;
        if (fifo_count !== 4'd0 || rd_data_valid !== 1'b0 || idle !== 1'b1 || wr_ready !== 1'b1)
            $display("FAIL mid_state: cnt=%0d vld=%b idle=%b ready=%b want 0 0 1 1",
                     fifo_count, rd_data_valid, idle, wr_ready);
        else pass_cnt++;
        total++;
        if ({bram_en, bram_we, rd_gnt} !== 3'b000 || bram_addr !== 32'h0 || bram_wdata !== 32'h0)
            $display("FAIL mid_bus: en/we/gnt=%b%b%b addr=%h wdata=%h want 000 0 0",
                     bram_en, bram_we, rd_gnt, bram_addr, bram_wdata);
        else pass_cnt++;
        step(); step();
        reset_n = 1'b1; rd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bram_we) w++;
            step();
        end
        total++;
        if (w != 0)
            $display("FAIL mid_nowrite: writes=%0d want 0", w);
        else pass_cnt++;
        wr_valid = 1'b1; wr_data = 32'h1234_5678;
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 32'h0 || bram_wdata !== 32'h1234_5678)
            $display("FAIL mid_new: we=%b addr=%h data=%h want 1 0 12345678",
                     bram_we, bram_addr, bram_wdata);
        else pass_cnt++;
        step();
        @(negedge clk);
        total++;
        if (ofm_wr_count !== 32'd1)
            $display("FAIL mid_cnt: wcnt=%0d want 1", ofm_wr_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full();
        test_read();
        test_write_drain();
        test_starvation();
        test_ofm_collision();
        test_watermark();
        test_reset_mid();
        step(); step();
        total++;
        if (wr_q.size() != 0 || rd_q.size() != 0)
            $display("FAIL sb_empty: wr_q=%0d rd_q=%0d want 0 0", wr_q.size(), rd_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
